servo_cmd_pwm: RTL

Parametrised multi-channel servo controller. It parses framed angle commands from the UART receive path, holding `RxData` and the one-cycle `RxDone` strobe. It drives `NCH` independent 50 Hz servo PWM outputs from one shared period counter, with glitch-free updates at period boundaries. It replaces the single-channel UI/PWM pairing between the UART receiver and the GPIO header.

---
 rtl/servo_pkg.sv | 38 +++
 rtl/servo_frame_parser.sv | 92 +++++++++
 rtl/servo_cmd_pwm.sv | 97 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared constants, parser state encoding and angle-to-pulse-width conversion
// for the multi-channel servo controller.
package servo_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHAN,
        ST_ANG,
        ST_CSUM
    } parser_state_t;

    // Width of one angle step in clock cycles, truncated.
    function automatic logic [31:0] step_cycles(
        input int unsigned clk_hz,
        input int unsigned min_us,
        input int unsigned max_us,
        input int unsigned angle_max
    );
        int unsigned cyc_per_us;
        cyc_per_us = clk_hz / 1_000_000;
        return ((max_us - min_us) * cyc_per_us) / angle_max;
    endfunction

    function automatic logic [31:0] angle_to_cycles(
        input int unsigned angle,
        input int unsigned clk_hz,
        input int unsigned min_us,
        input int unsigned max_us,
        input int unsigned angle_max
    );
        int unsigned min_cyc;
        min_cyc = min_us * (clk_hz / 1_000_000);
        return min_cyc + angle * step_cycles(clk_hz, min_us, max_us, angle_max);
    endfunction

endpackage

// File: rtl/servo_frame_parser.sv
// Parses FF/channel/angle/checksum frames from the UART byte stream and
// issues a one-cycle shadow write plus registered accept/reject pulses.
module servo_frame_parser
    import servo_pkg::*;
#(
    parameter int NCH         = 16,
    parameter int ANGLE_MAX   = 180,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] RxData,
    input  logic       RxDone,
    output logic       wr_en,
    output logic [7:0] wr_ch,
    output logic [7:0] wr_angle,
    output logic       CmdAck,
    output logic       CmdErr
);

    localparam logic [7:0]  NCH_LIM      = 8'(NCH);
    localparam logic [7:0]  ANGLE_LIM    = 8'(ANGLE_MAX);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    parser_state_t state_reg;
    logic [7:0]    chan_reg;
    logic [7:0]    angle_reg;
    logic [31:0]   gap_reg;

    logic timeout_fire;
    logic frame_ok;
    logic csum_byte;

    // The timeout outranks a byte arriving in the same cycle.
    assign timeout_fire = (state_reg != ST_IDLE) && (gap_reg == TIMEOUT_LAST);
    assign frame_ok     = (chan_reg < NCH_LIM) && (angle_reg <= ANGLE_LIM)
                          && ((chan_reg ^ angle_reg) == RxData);
    assign csum_byte    = RxDone && !timeout_fire && (state_reg == ST_CSUM)
                          && (RxData != SYNC_BYTE);

    assign wr_en    = csum_byte && frame_ok;
    assign wr_ch    = chan_reg;
    assign wr_angle = angle_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= ST_IDLE;
            chan_reg  <= 8'd0;
            angle_reg <= 8'd0;
            gap_reg   <= 32'd0;
            CmdAck    <= 1'b0;
            CmdErr    <= 1'b0;
        end else begin
            CmdAck <= 1'b0;
            CmdErr <= 1'b0;

            if (state_reg == ST_IDLE || RxDone) begin
                gap_reg <= 32'd0;
            end else begin
                gap_reg <= gap_reg + 32'd1;
            end

            if (timeout_fire) begin
                state_reg <= ST_IDLE;
                gap_reg   <= 32'd0;
                CmdErr    <= 1'b1;
            end else if (RxDone) begin
                if (RxData == SYNC_BYTE) begin
                    state_reg <= ST_CHAN;
                end else begin
                    case (state_reg)
                        ST_CHAN: begin
                            chan_reg  <= RxData;
                            state_reg <= ST_ANG;
                        end
                        ST_ANG: begin
                            angle_reg <= RxData;
                            state_reg <= ST_CSUM;
                        end
                        ST_CSUM: begin
                            state_reg <= ST_IDLE;
                            CmdAck    <= frame_ok;
                            CmdErr    <= !frame_ok;
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/servo_cmd_pwm.sv
// NCH-channel servo PWM driven by one shared period counter; new widths are
// staged in shadow registers and committed to all channels at the period wrap.
module servo_cmd_pwm
    import servo_pkg::*;
#(
    parameter int NCH         = 16,
    parameter int CLK_HZ      = 50_000_000,
    parameter int PERIOD_HZ   = 50,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int ANGLE_MAX   = 180,
    parameter int RESET_ANGLE = 90,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [7:0]     RxData,
    input  logic           RxDone,
    output logic [NCH-1:0] Pwm,
    output logic           CmdAck,
    output logic           CmdErr
);

    localparam logic [31:0] PERIOD_LAST = 32'(CLK_HZ / PERIOD_HZ - 1);
    localparam logic [31:0] MIN_CYC     = angle_to_cycles(0, CLK_HZ, MIN_US, MAX_US, ANGLE_MAX);
    localparam logic [31:0] STEP_CYC    = step_cycles(CLK_HZ, MIN_US, MAX_US, ANGLE_MAX);
    localparam logic [31:0] RESET_DUR   = angle_to_cycles(RESET_ANGLE, CLK_HZ, MIN_US, MAX_US,
                                                          ANGLE_MAX);

    logic        wr_en;
    logic [7:0]  wr_ch;
    logic [7:0]  wr_angle;
    logic [31:0] wr_dur;
    logic [31:0] count_reg;
    logic [31:0] count_next;
    logic        wrap;

    servo_frame_parser #(
        .NCH         (NCH),
        .ANGLE_MAX   (ANGLE_MAX),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_parser (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_angle (wr_angle),
        .CmdAck   (CmdAck),
        .CmdErr   (CmdErr)
    );

    // Single multiply-add shared by all channels; only the addressed one latches it.
    assign wr_dur = MIN_CYC + 32'(wr_angle) * STEP_CYC;

    assign wrap       = (count_reg == PERIOD_LAST);
    assign count_next = wrap ? 32'd0 : count_reg + 32'd1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_reg <= 32'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [31:0] shadow_reg;
            logic [31:0] active_reg;
            logic        pwm_reg;

            // A write landing on the wrap cycle misses this commit; active
            // takes the pre-write shadow and the new width follows a period later.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    shadow_reg <= RESET_DUR;
                    active_reg <= RESET_DUR;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (wr_en && (wr_ch == 8'(gi))) begin
                        shadow_reg <= wr_dur;
                    end
                    if (wrap) begin
                        active_reg <= shadow_reg;
                    end
                    pwm_reg <= (count_reg < active_reg);
                end
            end

            assign Pwm[gi] = pwm_reg;
        end
    endgenerate

endmodule
